// File: rtl/ryuki_datatypes.sv
`default_nettype none
//==============================================================================
// Package     : ryuki_datatypes
// Description : Shared datatypes for the trace path. trace_output is one
//               captured trace element as produced by the upstream tracker.
// Revision    : 1.0 - initial release
//==============================================================================
package ryuki_datatypes;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] payload;
    } trace_output;

endpackage
`default_nettype wire

// File: rtl/trace_ingress_fifo.sv
`default_nettype none
//==============================================================================
// Module      : trace_ingress_fifo
// Description : Show-ahead FIFO between the upstream trace tracker (push
//               strobe) and the downstream tracker (pop strobe). The head
//               entry is held in a register so the consumer samples it on
//               the popping edge. Sticky overflow/underflow flags record
//               dropped pushes and pops requested while empty.
//               Optional statistics (high_water, drop_count) are built only
//               when the macro TRACE_INGRESS_STATS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module trace_ingress_fifo #(
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ready_signal,
    input  ryuki_datatypes::trace_output trace_element_in,
    input  logic                         data_request,
    output logic                         data_present,
    output ryuki_datatypes::trace_output trace_element_out,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
`ifdef TRACE_INGRESS_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]       high_water,
    output logic [15:0]                  drop_count
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_afull = c_cnt_w'(AFULL_LEVEL);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    ryuki_datatypes::trace_output mem_q [DEPTH];
    ryuki_datatypes::trace_output head_q, head_d;

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0] w_rd_next;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               data_present_q;
    logic               almost_full_q;
    logic               overflow_q;
    logic               underflow_q;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;

    // Handshake decode, pointer/count next state and head-register selection
    always_comb begin
        w_pop     = data_request & data_present_q;
        // A pop on the same edge frees a slot, so a full FIFO still accepts
        w_push    = ready_signal & ((count_q != c_depth) | w_pop);
        w_drop    = ready_signal & ~w_push;
        w_rd_next = rd_ptr_q + c_ptr_w'(1);

        wr_ptr_d  = w_push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
        rd_ptr_d  = w_pop  ? w_rd_next : rd_ptr_q;

        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + c_one;
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_one;
        end

        // Head follows the oldest live entry; with more than one entry the
        // successor is already stored, otherwise it can only come from the
        // input bus. When the last entry leaves with no push, keep the stale
        // value (data_present drops to qualify it).
        head_d = head_q;
        if (w_pop) begin
            if (count_q != c_one) begin
                head_d = mem_q[w_rd_next];
            end else if (w_push) begin
                head_d = trace_element_in;
            end
        end else if (w_push && (count_q == '0)) begin
            head_d = trace_element_in;
        end
    end

    // Control state: pointers, occupancy, flags and head register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            data_present_q <= 1'b0;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            head_q         <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            data_present_q <= (count_d != '0);
            almost_full_q  <= (count_d >= c_afull);
            overflow_q     <= overflow_q | w_drop;
            underflow_q    <= underflow_q | (data_request & ~data_present_q);
            head_q         <= head_d;
        end
    end

    // Storage array; contents are don't-care after reset since pointers clear
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= trace_element_in;
        end
    end

    assign data_present      = data_present_q;
    assign trace_element_out = head_q;
    assign count             = count_q;
    assign almost_full       = almost_full_q;
    assign overflow          = overflow_q;
    assign underflow         = underflow_q;

`ifdef TRACE_INGRESS_STATS_EN
    logic [c_cnt_w-1:0] high_water_q;
    logic [15:0]        drop_count_q;

    // Peak occupancy and saturating count of dropped pushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_water_q <= '0;
            drop_count_q <= '0;
        end else begin
            if (count_d > high_water_q) begin
                high_water_q <= count_d;
            end
            if (w_drop && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign high_water = high_water_q;
    assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trace_ingress_fifo.sv
`default_nettype none
//==============================================================================
// Module      : tb_trace_ingress_fifo
// Description : Scoreboard bench for trace_ingress_fifo. Instance 0 uses
//               DEPTH=8, instance 1 uses DEPTH=4. Stimulus enqueues the
//               expected element order; negedge monitors pop and compare
//               whenever a pop is presented to the DUT. Directed checks
//               cover counts and flags. Statistics outputs are checked when
//               TRACE_INGRESS_STATS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_trace_ingress_fifo;
    import ryuki_datatypes::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rdy;
    logic [1:0]  req;
    logic [1:0]  dp;
    logic [1:0]  af;
    logic [1:0]  ovf;
    logic [1:0]  udf;
    trace_output din  [2];
    trace_output dout [2];
    logic [3:0]  cnt8;
    logic [2:0]  cnt4;
`ifdef TRACE_INGRESS_STATS_EN
    logic [3:0]  hw8;
    logic [15:0] dc8;
    logic [2:0]  hw4;
    logic [15:0] dc4;
`endif

    int checks = 0;
    int errors = 0;
    int s      = 0;
    int mcnt   [2];
    int mdepth [2];
    trace_output q0 [$];
    trace_output q1 [$];

    always #5 clk = ~clk;

    trace_ingress_fifo #(.DEPTH(8)) u_dut8 (
        .clk               (clk),
        .rst               (rst),
        .ready_signal      (rdy[0]),
        .trace_element_in  (din[0]),
        .data_request      (req[0]),
        .data_present      (dp[0]),
        .trace_element_out (dout[0]),
        .count             (cnt8),
        .almost_full       (af[0]),
        .overflow          (ovf[0]),
        .underflow         (udf[0])
`ifdef TRACE_INGRESS_STATS_EN
        ,
        .high_water        (hw8),
        .drop_count        (dc8)
`endif
    );

    trace_ingress_fifo #(.DEPTH(4)) u_dut4 (
        .clk               (clk),
        .rst               (rst),
        .ready_signal      (rdy[1]),
        .trace_element_in  (din[1]),
        .data_request      (req[1]),
        .data_present      (dp[1]),
        .trace_element_out (dout[1]),
        .count             (cnt4),
        .almost_full       (af[1]),
        .overflow          (ovf[1]),
        .underflow         (udf[1])
`ifdef TRACE_INGRESS_STATS_EN
        ,
        .high_water        (hw4),
        .drop_count        (dc4)
`endif
    );

    function automatic trace_output mk(input int i);
        trace_output t;
        t.tag     = 8'(i);
        t.payload = 32'hA000_0000 + 32'(i);
        return t;
    endfunction

    function automatic int cnt_of(input int i);
        return (i == 0) ? int'(cnt8) : int'(cnt4);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_el(input string nm, input trace_output act, input trace_output exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock of stimulus on instance s; expected order recorded at issue
    task automatic cyc(input logic push, input trace_output d, input logic pop);
        logic pop_eff;
        logic push_eff;
        pop_eff  = pop && (mcnt[s] > 0);
        push_eff = push && ((mcnt[s] < mdepth[s]) || pop_eff);
        if (push_eff) begin
            if (s == 0) q0.push_back(d);
            else        q1.push_back(d);
        end
        rdy[s] = push;
        req[s] = pop;
        din[s] = d;
        @(posedge clk);
        #1;
        mcnt[s] = mcnt[s] + int'(push_eff) - int'(pop_eff);
        rdy[s] = 1'b0;
        req[s] = 1'b0;
    endtask

    // Monitor for the DEPTH=8 instance: head must match the oldest expected
    always @(negedge clk) begin
        if (!rst && req[0] && dp[0]) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL pop8_unexpected: got %h expected none", dout[0]);
            end else begin
                if (dout[0] !== q0[0]) begin
                    errors++;
                    $display("FAIL pop8_order: got %h expected %h", dout[0], q0[0]);
                end
                void'(q0.pop_front());
            end
        end
    end

    // Monitor for the DEPTH=4 instance
    always @(negedge clk) begin
        if (!rst && req[1] && dp[1]) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL pop4_unexpected: got %h expected none", dout[1]);
            end else begin
                if (dout[1] !== q1[0]) begin
                    errors++;
                    $display("FAIL pop4_order: got %h expected %h", dout[1], q1[0]);
                end
                void'(q1.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        rdy       = '0;
        req       = '0;
        din[0]    = '0;
        din[1]    = '0;
        mcnt[0]   = 0;
        mcnt[1]   = 0;
        mdepth[0] = 8;
        mdepth[1] = 4;

        // Reset state
        #3;
        chk("rst_dp",    int'(dp[0]), 0);
        chk("rst_cnt",   cnt_of(0), 0);
        chk("rst_af",    int'(af[0]), 0);
        chk("rst_ovf",   int'(ovf[0]), 0);
        chk("rst_udf",   int'(udf[0]), 0);
        chk_el("rst_dout", dout[0], '0);
        #9;
        rst = 1'b0;

        // Single push, then pop two cycles later
        s = 0;
        cyc(1'b1, mk(1000), 1'b0);
        chk("a_dp", int'(dp[0]), 1);
        chk("a_cnt", cnt_of(0), 1);
        chk_el("a_dout", dout[0], mk(1000));
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        chk("a_pop_cnt", cnt_of(0), 0);
        chk("a_pop_dp", int'(dp[0]), 0);
        chk_el("a_hold_dout", dout[0], mk(1000));

        // Pop while empty
        chk("udf_before", int'(udf[0]), 0);
        cyc(1'b0, '0, 1'b1);
        chk("udf_set", int'(udf[0]), 1);
        chk("udf_cnt", cnt_of(0), 0);
        cyc(1'b1, mk(1001), 1'b0);
        chk("udf_push_cnt", cnt_of(0), 1);
        chk_el("udf_push_dout", dout[0], mk(1001));
        cyc(1'b0, '0, 1'b1);

        // Fill past full
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, mk(i), 1'b0);
            if (i == 5) chk("af_at5", int'(af[0]), 0);
            if (i == 6) chk("af_at6", int'(af[0]), 1);
            if (i == 8) chk("ovf_at8", int'(ovf[0]), 0);
        end
        chk("full_cnt", cnt_of(0), 8);
        chk("full_af", int'(af[0]), 1);
        chk("full_ovf", int'(ovf[0]), 1);
        chk_el("full_head", dout[0], mk(1));

        // Push and pop together while full
        cyc(1'b1, mk(77), 1'b1);
        chk("fullpp_cnt", cnt_of(0), 8);
        chk_el("fullpp_head", dout[0], mk(2));

        // Drain with data_request held high
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
        chk("drain_cnt", cnt_of(0), 0);
        chk("drain_dp", int'(dp[0]), 0);
        chk("drain_af", int'(af[0]), 0);
`ifdef TRACE_INGRESS_STATS_EN
        chk("stat_drop", int'(dc8), 1);
        chk("stat_hw", int'(hw8), 8);
`endif

        // Push and pop together at count=1
        cyc(1'b1, mk(200), 1'b0);
        cyc(1'b1, mk(201), 1'b1);
        chk("c1pp_cnt", cnt_of(0), 1);
        chk_el("c1pp_dout", dout[0], mk(201));
        cyc(1'b0, '0, 1'b1);
        chk_el("c1_hold", dout[0], mk(201));
        chk("c1_dp", int'(dp[0]), 0);

        // Push and pop together at count=0
        cyc(1'b1, mk(300), 1'b1);
        chk("c0pp_cnt", cnt_of(0), 1);
        chk_el("c0pp_dout", dout[0], mk(300));
        cyc(1'b0, '0, 1'b1);

        // DEPTH=4: wrap the pointers with count held at 3
        s = 1;
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(20 + i), 1'b0);
        chk("w_cnt3", cnt_of(1), 3);
        chk("w_af", int'(af[1]), 1);
        for (int i = 0; i < 10; i++) cyc(1'b1, mk(23 + i), 1'b1);
        chk("w_pairs_cnt", cnt_of(1), 3);
        chk_el("w_pairs_head", dout[1], mk(30));

        // Reset mid-operation with push and pop requested
        rdy[1] = 1'b1;
        req[1] = 1'b1;
        din[1] = mk(99);
        #2;
        rst = 1'b1;
        q1.delete();
        mcnt[1] = 0;
        #1;
        chk("mr_dp", int'(dp[1]), 0);
        chk("mr_cnt", cnt_of(1), 0);
        chk("mr_af", int'(af[1]), 0);
        chk_el("mr_dout", dout[1], '0);
        chk("mr_ovf8", int'(ovf[0]), 0);
        chk("mr_udf8", int'(udf[0]), 0);
        @(posedge clk);
        #1;
        chk("mr_edge_cnt", cnt_of(1), 0);
        chk("mr_edge_dp", int'(dp[1]), 0);
        rst    = 1'b0;
        rdy[1] = 1'b0;
        req[1] = 1'b0;

        // First push right after reset, then more wrapping pairs
        cyc(1'b1, mk(40), 1'b0);
        chk("ar_cnt", cnt_of(1), 1);
        chk_el("ar_dout", dout[1], mk(40));
        cyc(1'b1, mk(41), 1'b0);
        cyc(1'b1, mk(42), 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, mk(43 + i), 1'b1);
        chk("ar_pairs_cnt", cnt_of(1), 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        chk("ar_drain_cnt", cnt_of(1), 0);
        chk("ar_udf", int'(udf[1]), 0);

        // Every expected element must have been observed
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
